// File: rtl/matrix_mult_check.sv
// Loads two 5x5 8-bit matrices, streams C = A*B (mod 256) row-major; first result 6 cycles after the last load beat.
// Stalls indefinitely on out_ready low. Optional scaled-identity flag on the last element under MATMUL_IDENT_CHECK_EN.
module matrix_mult_check (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       ident_ok
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] beat_q, beat_d;
    logic [2:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] a_q [25];
    logic [7:0] a_d [25];
    logic [7:0] b_q [25];
    logic [7:0] b_d [25];
    logic       load_ready_q, load_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;

    logic [4:0] a_idx, b_idx, ld_idx;
    logic [7:0] prod;
    logic       last_elem;

`ifdef MATMUL_IDENT_CHECK_EN
    logic       flag_q, flag_d, flag_now;
    logic [7:0] c0_q, c0_d;
    logic       ident_ok_q, ident_ok_d;
`endif

    assign a_idx     = {i_q, 2'b00} + {2'b00, i_q} + {2'b00, k_q};
    assign b_idx     = {k_q, 2'b00} + {2'b00, k_q} + {2'b00, j_q};
    assign prod      = a_q[a_idx] * b_q[b_idx];
    assign last_elem = (i_q == 3'd4) && (j_q == 3'd4);
    // Beats 25..49 land at B[beat-25]; subtracting in 5 bits wraps to exactly that.
    assign ld_idx    = beat_q[4:0] - 5'd25;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef MATMUL_IDENT_CHECK_EN
        flag_d      = flag_q;
        flag_now    = flag_q;
        c0_d        = c0_q;
        ident_ok_d  = ident_ok_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (load_valid && load_ready_q) begin
                    if (beat_q < 6'd25) a_d[beat_q[4:0]] = load_data;
                    else                b_d[ld_idx]      = load_data;
                    if (beat_q == 6'd49) begin
                        beat_d  = 6'd0;
                        state_d = ST_MAC;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            ST_MAC: begin
                acc_d = (k_q == 3'd0) ? prod : acc_q + prod;
                if (k_q == 3'd4) begin
                    k_d     = 3'd0;
                    state_d = ST_EMIT;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (!out_valid_q) begin
                    // Register stage: present the finished accumulator.
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_last_d  = last_elem;
`ifdef MATMUL_IDENT_CHECK_EN
                    if (i_q == 3'd0 && j_q == 3'd0) begin
                        c0_d     = acc_q;
                        flag_now = (acc_q != 8'd0);
                    end else if (i_q == j_q) begin
                        flag_now = flag_q && (acc_q != 8'd0) && (acc_q == c0_q);
                    end else begin
                        flag_now = flag_q && (acc_q == 8'd0);
                    end
                    flag_d     = flag_now;
                    ident_ok_d = last_elem && flag_now;
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = 8'd0;
                    out_last_d  = 1'b0;
`ifdef MATMUL_IDENT_CHECK_EN
                    ident_ok_d  = 1'b0;
`endif
                    if (last_elem) begin
                        state_d = ST_LOAD;
                        i_d     = 3'd0;
                        j_d     = 3'd0;
                        k_d     = 3'd0;
                        beat_d  = 6'd0;
                        acc_d   = 8'd0;
`ifdef MATMUL_IDENT_CHECK_EN
                        flag_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_MAC;
                        if (j_q == 3'd4) begin
                            j_d = 3'd0;
                            i_d = i_q + 3'd1;
                        end else begin
                            j_d = j_q + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_LOAD;
                beat_d      = 6'd0;
                i_d         = 3'd0;
                j_d         = 3'd0;
                k_d         = 3'd0;
                out_valid_d = 1'b0;
                out_data_d  = 8'd0;
                out_last_d  = 1'b0;
`ifdef MATMUL_IDENT_CHECK_EN
                flag_d      = 1'b1;
                ident_ok_d  = 1'b0;
`endif
            end
        endcase
        load_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            beat_q       <= 6'd0;
            i_q          <= 3'd0;
            j_q          <= 3'd0;
            k_q          <= 3'd0;
            acc_q        <= 8'd0;
            for (int n = 0; n < 25; n++) begin
                a_q[n] <= 8'd0;
                b_q[n] <= 8'd0;
            end
            load_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

`ifdef MATMUL_IDENT_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q     <= 1'b1;
            c0_q       <= 8'd0;
            ident_ok_q <= 1'b0;
        end else begin
            flag_q     <= flag_d;
            c0_q       <= c0_d;
            ident_ok_q <= ident_ok_d;
        end
    end
    assign ident_ok = ident_ok_q;
`else
    assign ident_ok = 1'b0;
`endif

    assign load_ready = load_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_matrix_mult_check.sv
// Directed bench for matrix_mult_check: identity, scaled, wrap-around, stall, mid-run reset, back-to-back loads.
module tb_matrix_mult_check;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       ident_ok;

    int errs   = 0;
    int checks = 0;

    logic [7:0] ma [25];
    logic [7:0] mb [25];
    logic [7:0] mc [25];

    matrix_mult_check dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ident_ok   (ident_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and hand-derived results: 0 = I*I, 1 = all-2 * 3I, 2 = all-16 * all-16, 3 = 2I * I.
    task automatic set_mats(input int kind);
        for (int n = 0; n < 25; n++) begin
            logic diag;
            diag = ((n / 5) == (n % 5));
            case (kind)
                0: begin ma[n] = diag ? 8'd1 : 8'd0; mb[n] = diag ? 8'd1 : 8'd0; mc[n] = diag ? 8'd1 : 8'd0; end
                1: begin ma[n] = 8'd2;               mb[n] = diag ? 8'd3 : 8'd0; mc[n] = 8'd6;               end
                2: begin ma[n] = 8'd16;              mb[n] = 8'd16;              mc[n] = 8'd0;               end
                default: begin ma[n] = diag ? 8'd2 : 8'd0; mb[n] = diag ? 8'd1 : 8'd0; mc[n] = diag ? 8'd2 : 8'd0; end
            endcase
        end
    endtask

    task automatic load_pair(input string name);
        int bad;
        bad = 0;
        for (int b = 0; b < 50; b++) begin
            load_valid = 1'b1;
            load_data  = (b < 25) ? ma[b] : mb[b - 25];
            if (load_ready !== 1'b1) bad++;
            tick();
        end
        load_valid = 1'b0;
        chk({name, "_load_ready_low_beats"}, bad, 0);
    endtask

    task automatic run_out(input string name, input int ident_exp, input int stall_at,
                           input int stall_len, input bit junk, input int stop_after);
        int lat, n, cyc, stalled, holdbad, lastbad, lrbad, id_exp;
        logic [7:0] hold;
        lat = 0; n = 0; cyc = 0; stalled = 0; holdbad = 0; lastbad = 0; lrbad = 0; hold = 8'd0;
`ifdef MATMUL_IDENT_CHECK_EN
        id_exp = ident_exp;
`else
        id_exp = 0;
`endif
        out_ready = 1'b1;
        while (!out_valid && lat < 40) begin
            if (junk) begin load_valid = 1'b1; load_data = 8'hA5; end
            if (load_ready) lrbad++;
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, 6);
        while (n < 25 && n != stop_after && cyc < 3000) begin
            out_ready = !(n == stall_at && stalled < stall_len);
            if (junk) begin load_valid = 1'b1; load_data = 8'($urandom_range(255)); end
            if (load_ready) lrbad++;
            if (!out_valid && out_last) lastbad++;
            if (!out_last && ident_ok) lastbad++;
            if (out_valid) begin
                if (out_last !== (n == 24)) lastbad++;
                if (!out_ready) begin
                    if (stalled == 0) hold = out_data;
                    else if (out_data !== hold) holdbad++;
                    stalled++;
                end else begin
                    chk($sformatf("%s_c%0d", name, n), out_data, mc[n]);
                    if (n == 24) chk({name, "_ident_ok"}, ident_ok, id_exp);
                    n++;
                end
            end
            tick();
            cyc++;
        end
        chk({name, "_last_and_ident_framing"}, lastbad, 0);
        chk({name, "_load_ready_busy"}, lrbad, 0);
        if (stall_at >= 0) begin
            chk({name, "_stall_cycles"}, stalled, stall_len);
            chk({name, "_stall_hold_changes"}, holdbad, 0);
            chk({name, "_stall_data"}, hold, mc[stall_at]);
        end
        if (stop_after < 0) begin
            chk({name, "_count"}, n, 25);
            chk({name, "_load_ready_after"}, load_ready, 1);
            chk({name, "_valid_after"}, out_valid, 0);
        end else begin
            chk({name, "_partial_count"}, n, stop_after);
        end
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'd0;
        out_ready  = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ident_ok", ident_ok, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        set_mats(0); load_pair("ident");  run_out("ident", 1, -1, 0, 1'b0, -1);
        set_mats(1); load_pair("scaled"); run_out("scaled", 0, -1, 0, 1'b0, -1);
        set_mats(2); load_pair("wrap");   run_out("wrap", 0, -1, 0, 1'b0, -1);
        set_mats(0); load_pair("stall");  run_out("stall", 1, 7, 10, 1'b1, -1);

        set_mats(0); load_pair("abort");  run_out("abort", 1, -1, 0, 1'b0, 12);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("abort_rst_load_ready", load_ready, 1);
        chk("abort_rst_out_valid", out_valid, 0);
        chk("abort_rst_out_data", out_data, 0);
        chk("abort_rst_out_last", out_last, 0);
        chk("abort_rst_ident_ok", ident_ok, 0);
        tick();
        reset = 1'b1;
        tick();
        set_mats(0); load_pair("reload"); run_out("reload", 1, -1, 0, 1'b0, -1);

        set_mats(0); load_pair("b2b_a"); run_out("b2b_a", 1, -1, 0, 1'b0, -1);
        set_mats(3); load_pair("b2b_b"); run_out("b2b_b", 1, -1, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/matrix_mult_check.md
MATRIX_MULT_CHECK -- requirements
Module: matrix_mult_check

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 load_valid  input  1  load_data carries a valid element.
REQ-005 load_data  input  8  element; first 25 beats = matrix A row-major (a0..a24), next 25 = matrix B row-major (b0..b24).
REQ-006 load_ready  output  1  block accepts a load beat; beat transfers when load_valid and load_ready are both high on a clk edge.
REQ-007 out_valid  output  1  out_data carries a product element.
REQ-008 out_ready  input  1  consumer accepts the element; transfer when out_valid and out_ready are both high.
REQ-009 out_data  output  8  element c(i,j) of C = A*B, row-major order.
REQ-010 out_last  output  1  high with out_valid on element c24 only.
REQ-011 ident_ok  output  1  scaled-identity result; meaningful only while out_last is high.

Function
REQ-012 States LOAD, MAC, EMIT only; any other encoding returns to LOAD on the next edge.
REQ-013 LOAD: load_ready=1; a 6-bit beat counter increments per transfer; the beat with counter=49 moves the state to MAC and clears the counter.
REQ-014 load_ready SHALL be 0 in MAC and EMIT; load_valid there is ignored.
REQ-015 MAC: 5 cycles per element, k=0..4, acc <= acc + A[i][k]*B[k][j]; the first MAC cycle of each element replaces acc with the product.
REQ-016 Arithmetic: 8-bit unsigned; products and sums wrap modulo 256; no saturation, no overflow flag.
REQ-017 After MAC k=4, state EMIT: out_valid=1, out_data=acc, held stable until the transfer.
REQ-018 Latency: first out_valid rises 6 cycles after the edge accepting beat 49 (5 MAC cycles plus 1 register stage).
REQ-019 EMIT transfer of element n<24 returns to MAC for element n+1 (j increments; wraps 4->0 with i incrementing); element 24 transfer returns to LOAD with all counters cleared.
REQ-020 out_ready held low stalls EMIT indefinitely without data change; no element is dropped or repeated.
REQ-021 out_valid SHALL be 0 outside EMIT; out_last=0 whenever out_valid=0.
REQ-022 Back-to-back: load_ready rises in the cycle after the last output transfer; the next A/B pair SHALL be accepted from that cycle.
REQ-023 Stored A and B are overwritten only by new LOAD beats.

Reset
REQ-024 reset low: state=LOAD, all counters=0, acc=0, A and B storage=0, ident tracking=1, load_ready=1, out_valid=0, out_data=0, out_last=0, ident_ok=0, all asynchronous.
REQ-025 Reset asserted mid-LOAD, MAC or EMIT discards the operation; after release a full 50-beat load is required.

Configuration
REQ-026 Macro MATMUL_IDENT_CHECK_EN defined: a tracking flag is cleared if any off-diagonal element is nonzero, if any diagonal element is 0, or if any diagonal element differs from c0; ident_ok = flag while out_last is high, else 0.
REQ-027 Macro MATMUL_IDENT_CHECK_EN undefined: tracking logic absent; ident_ok tied to 0; all other behaviour identical.

Verification
REQ-028 A=I, B=I, out_ready=1 -> 25 outputs 1,0,0,0,0,0,1,...; first out_valid 6 cycles after beat 49; ident_ok=1 on c24 (with macro).
REQ-029 A all elements 2, B=I scaled by 3 (diagonal 3) -> every c(i,j)=6; ident_ok=0.
REQ-030 A all 16, B all 16 -> each c = 5*256 mod 256 = 0; ident_ok=0 (zero diagonal).
REQ-031 A=I, B=I, out_ready low for 10 cycles at element 7 -> out_data=0 held stable, no loss; load_ready=0 throughout; load beats offered during MAC are ignored.
REQ-032 reset pulsed low during MAC of element 12 -> all outputs 0 immediately, load_ready=1; a fresh load of A=I, B=I yields the identity sequence.
REQ-033 Two back-to-back loads (I,I then A=2I, B=I) -> second run begins the cycle after first out_last transfer; outputs diagonal 2, ident_ok=1.
